// File: rtl/video_pkg.sv
// Shared video types for the line-window aligners.
//   PIX_W_DEFAULT / COORD_W_DEFAULT / LINE_MAX_DEFAULT : default geometry
//   pixel_t, coord_t : default-width pixel and coordinate types
//   win_state_e      : aligner state (IDLE, FILL, RUN, ERR)
package video_pkg;

  localparam int PIX_W_DEFAULT    = 24;
  localparam int COORD_W_DEFAULT  = 13;
  localparam int LINE_MAX_DEFAULT = 640;

  typedef logic [PIX_W_DEFAULT-1:0]   pixel_t;
  typedef logic [COORD_W_DEFAULT-1:0] coord_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2,
    ERR  = 2'd3
  } win_state_e;

endpackage

// File: rtl/line_buf_ram.sv
// One line of pixel storage: simple dual-port RAM, one write port and one
// read port with a registered (1-cycle) read. Contents are not reset.
//   clk   : clock
//   we    : write enable, waddr/wdata : write port
//   re    : read enable,  raddr       : read address
//   rdata : registered read data, holds while re=0
module line_buf_ram #(
  parameter int DEPTH = 640,
  parameter int WIDTH = 24,
  parameter int AW    = 10
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [0:DEPTH-1];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/line_window_center.sv
// Delays a raster pixel stream so that each output pixel is the centre of a
// KSIZE x KSIZE window ending at the newest accepted input pixel.
//   clk, rst_n  : clock, synchronous active-low reset
//   pix_valid   : input beat accepted this cycle
//   sof         : first pixel of a frame (qualified by pix_valid)
//   line_len    : pixels per line, sampled on an accepted sof beat
//   pix_in      : input pixel
//   pass_thru   : delayed centre pixel (holds between emissions)
//   pass_valid  : one-cycle strobe for pass_thru/center_col/center_row
//   center_col, center_row : coordinates of the emitted centre pixel
//   cfg_err     : sticky, set when a sof arrives with line_len out of range
// Optional (macro LINE_WINDOW_EDGE_FLAG_EN):
//   pass_edge   : centre window overlaps top/left/right image border
module line_window_center
  import video_pkg::*;
#(
  parameter int PIX_W    = PIX_W_DEFAULT,
  parameter int LINE_MAX = LINE_MAX_DEFAULT,
  parameter int KSIZE    = 11,
  parameter int COORD_W  = COORD_W_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               pix_valid,
  input  logic               sof,
  input  logic [COORD_W-1:0] line_len,
  input  logic [PIX_W-1:0]   pix_in,
  output logic [PIX_W-1:0]   pass_thru,
  output logic               pass_valid,
  output logic [COORD_W-1:0] center_col,
  output logic [COORD_W-1:0] center_row,
  output logic               cfg_err
`ifdef LINE_WINDOW_EDGE_FLAG_EN
  ,
  output logic               pass_edge
`endif
);

  localparam int R  = (KSIZE - 1) / 2;
  localparam int AW = (LINE_MAX > 1) ? $clog2(LINE_MAX) : 1;

  localparam logic [COORD_W-1:0] K_C    = COORD_W'(KSIZE);
  localparam logic [COORD_W-1:0] LMAX_C = COORD_W'(LINE_MAX);
  localparam logic [COORD_W-1:0] R_C    = COORD_W'(R);
  localparam logic [COORD_W-1:0] ONE_C  = COORD_W'(1);

  win_state_e         state;
  logic [COORD_W-1:0] len_q;
  logic [COORD_W-1:0] wcol;
  logic [COORD_W-1:0] waddr;
  logic [COORD_W-1:0] raddr;
  logic [COORD_W-1:0] ccol;
  logic [COORD_W-1:0] crow;
  logic [31:0]        cnt;
  logic [31:0]        fill_tgt;
  logic               len_ok;
  logic               sof_ok;
  logic               sof_bad;
  logic               in_frame;
  logic               emit;

  logic [PIX_W-1:0]   tap [0:R];
  logic [PIX_W-1:0]   sh  [0:R-1];

  always_comb begin
    len_ok   = (line_len >= K_C) && (line_len <= LMAX_C);
    sof_ok   = pix_valid && sof && len_ok;
    sof_bad  = pix_valid && sof && !len_ok;
    in_frame = (state == FILL) || (state == RUN);
    emit     = pix_valid && !sof &&
               ((state == RUN) || ((state == FILL) && (cnt == fill_tgt)));
    waddr    = sof_ok ? '0 : wcol;
    // The read address runs one column ahead of the write address so the
    // registered read is already holding the column the next beat writes;
    // that makes each buffer an exact one-line delay even across gaps.
    if (sof_ok)
      raddr = ONE_C;
    else if (wcol == len_q - ONE_C)
      raddr = '0;
    else
      raddr = wcol + ONE_C;
  end

  assign tap[0] = pix_in;

  for (genvar i = 0; i < R; i++) begin : g_line
    line_buf_ram #(
      .DEPTH (LINE_MAX),
      .WIDTH (PIX_W),
      .AW    (AW)
    ) u_buf (
      .clk   (clk),
      .we    (pix_valid),
      .waddr (AW'(waddr)),
      .wdata (tap[i]),
      .re    (pix_valid),
      .raddr (AW'(raddr)),
      .rdata (tap[i+1])
    );
  end

  // Horizontal part of the centre delay: R more accepted beats.
  always_ff @(posedge clk) begin
    if (pix_valid) begin
      sh[0] <= tap[R];
      for (int unsigned j = 1; j < R; j++) sh[j] <= sh[j-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      len_q      <= '0;
      wcol       <= '0;
      ccol       <= '0;
      crow       <= '0;
      cnt        <= '0;
      fill_tgt   <= '0;
      pass_thru  <= '0;
      pass_valid <= 1'b0;
      center_col <= '0;
      center_row <= '0;
      cfg_err    <= 1'b0;
`ifdef LINE_WINDOW_EDGE_FLAG_EN
      pass_edge  <= 1'b0;
`endif
    end else begin
      pass_valid <= 1'b0;
      if (sof_ok) begin
        // sof beat is n=0 of the new frame; next beat is n=1
        state    <= FILL;
        len_q    <= line_len;
        fill_tgt <= 32'(R) * 32'(line_len) + 32'(R);
        cnt      <= 32'd1;
        wcol     <= raddr;
        ccol     <= '0;
        crow     <= '0;
      end else if (sof_bad) begin
        state   <= ERR;
        cfg_err <= 1'b1;
      end else if (pix_valid && in_frame) begin
        wcol <= raddr;
        if (state == FILL) begin
          if (cnt == fill_tgt) state <= RUN;
          else                 cnt   <= cnt + 32'd1;
        end
        if (emit) begin
          pass_valid <= 1'b1;
          pass_thru  <= sh[R-1];
          center_col <= ccol;
          center_row <= crow;
`ifdef LINE_WINDOW_EDGE_FLAG_EN
          pass_edge  <= (crow < R_C) || (ccol < R_C) || (ccol >= len_q - R_C);
`endif
          if (ccol == len_q - ONE_C) begin
            ccol <= '0;
            if (crow != '1) crow <= crow + ONE_C;
          end else begin
            ccol <= ccol + ONE_C;
          end
        end
      end
    end
  end

`ifndef LINE_WINDOW_EDGE_FLAG_EN
  logic unused_r;
  assign unused_r = ^R_C;
`endif

endmodule

// File: tb/tb_line_window_center.sv
module tb_line_window_center;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pix_valid;
  logic        sof;
  logic [12:0] line_len;
  logic [23:0] pix_in;
  logic [23:0] pass_thru;
  logic        pass_valid;
  logic [12:0] center_col;
  logic [12:0] center_row;
  logic        cfg_err;
`ifdef LINE_WINDOW_EDGE_FLAG_EN
  logic        pass_edge;
  logic [23:0] e_thru;
  logic        e_valid;
  logic [12:0] e_col;
  logic [12:0] e_row;
  logic        e_err;
  logic        e_edge;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  logic [23:0] exp_last;

  always #5 clk = ~clk;

  line_window_center #(
    .PIX_W    (24),
    .LINE_MAX (640),
    .KSIZE    (3),
    .COORD_W  (13)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pix_valid  (pix_valid),
    .sof        (sof),
    .line_len   (line_len),
    .pix_in     (pix_in),
    .pass_thru  (pass_thru),
    .pass_valid (pass_valid),
    .center_col (center_col),
    .center_row (center_row),
    .cfg_err    (cfg_err)
`ifdef LINE_WINDOW_EDGE_FLAG_EN
    ,
    .pass_edge  (pass_edge)
`endif
  );

`ifdef LINE_WINDOW_EDGE_FLAG_EN
  line_window_center #(
    .PIX_W    (24),
    .LINE_MAX (640),
    .KSIZE    (5),
    .COORD_W  (13)
  ) dut5 (
    .clk        (clk),
    .rst_n      (rst_n),
    .pix_valid  (pix_valid),
    .sof        (sof),
    .line_len   (line_len),
    .pix_in     (pix_in),
    .pass_thru  (e_thru),
    .pass_valid (e_valid),
    .center_col (e_col),
    .center_row (e_row),
    .cfg_err    (e_err),
    .pass_edge  (e_edge)
  );
`endif

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Apply one cycle of inputs, then sample 1 time unit after the edge.
  task automatic drive(input bit v, input bit s, input int len, input int pix);
    pix_valid = v;
    sof       = s;
    line_len  = 13'(len);
    pix_in    = 24'(pix);
    @(posedge clk);
    #1;
  endtask

  // Frame of nbeats accepted pixels base+n (sof on n=0), KSIZE=3 model:
  // beat n >= len+1 emits pixel n-(len+1) at column/row of that index.
  task automatic stream(input int len, input int base, input int nbeats, input bit gaps);
    int d;
    int n;
    int cyc;
    bit v;
    d   = len + 1;
    n   = 0;
    cyc = 0;
    while (n < nbeats) begin
      v = !gaps || (cyc % 4 == 0) || (cyc % 4 == 3);
      drive(v, v && (n == 0), len, base + n);
      if (v && n >= d) begin
        exp_last = 24'(base + n - d);
        chk("valid_emit", 32'(pass_valid), 32'd1);
        chk("pass_thru", 32'(pass_thru), 32'(exp_last));
        chk("center_col", 32'(center_col), 32'((n - d) % len));
        chk("center_row", 32'(center_row), 32'((n - d) / len));
      end else begin
        chk("valid_idle", 32'(pass_valid), 32'd0);
        chk("thru_hold", 32'(pass_thru), 32'(exp_last));
      end
      if (v) n++;
      cyc++;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    exp_last = '0;
    drive(0, 0, 8, 0);
    drive(0, 0, 8, 0);
    chk("rst_valid", 32'(pass_valid), 32'd0);
    chk("rst_thru", 32'(pass_thru), 32'd0);
    chk("rst_col", 32'(center_col), 32'd0);
    chk("rst_row", 32'(center_row), 32'd0);
    chk("rst_err", 32'(cfg_err), 32'd0);
    rst_n = 1'b1;
    drive(0, 0, 8, 0);

    // Fill/align: 64 continuous pixels, first output after beat 9.
    stream(8, 0, 64, 1'b0);
    // Gaps: valid pattern 1,0,0,1 gives the same sequence.
    stream(8, 0, 40, 1'b1);
    // Restart at beat 30 with line_len=6: 7 silent beats, then new pixel 0.
    stream(8, 0, 30, 1'b0);
    stream(6, 100, 20, 1'b0);

    // Configuration errors: too short, then too long.
    drive(1, 1, 2, 7);
    chk("err_short", 32'(cfg_err), 32'd1);
    chk("err_short_valid", 32'(pass_valid), 32'd0);
    for (int i = 0; i < 12; i++) begin
      drive(1, 0, 2, i);
      chk("err_hold_valid", 32'(pass_valid), 32'd0);
    end
    drive(1, 1, 700, 9);
    chk("err_long", 32'(cfg_err), 32'd1);
    chk("err_long_valid", 32'(pass_valid), 32'd0);
    stream(8, 200, 20, 1'b0);
    chk("err_sticky", 32'(cfg_err), 32'd1);

    // Reset mid-frame.
    stream(8, 300, 20, 1'b0);
    rst_n = 1'b0;
    drive(1, 0, 8, 320);
    chk("mid_rst_valid", 32'(pass_valid), 32'd0);
    chk("mid_rst_thru", 32'(pass_thru), 32'd0);
    chk("mid_rst_col", 32'(center_col), 32'd0);
    chk("mid_rst_row", 32'(center_row), 32'd0);
    chk("mid_rst_err", 32'(cfg_err), 32'd0);
    rst_n = 1'b1;
    exp_last = '0;
    for (int i = 0; i < 15; i++) begin
      drive(1, 0, 8, 321 + i);
      chk("no_sof_valid", 32'(pass_valid), 32'd0);
    end
    stream(8, 400, 12, 1'b0);

    // Row boundary spot check: second line, pixel index 8 at (0,1).
    stream(8, 0, 18, 1'b0);
    chk("row1_thru", 32'(pass_thru), 32'd8);
    chk("row1_col", 32'(center_col), 32'd0);
    chk("row1_row", 32'(center_row), 32'd1);

`ifdef LINE_WINDOW_EDGE_FLAG_EN
    // KSIZE=5, line_len=10: delay 22, border = rows 0,1 / cols 0,1,8,9.
    for (int n = 0; n < 70; n++) begin
      drive(1, n == 0, 10, n);
      if (n >= 22) begin
        int c;
        int r;
        c = (n - 22) % 10;
        r = (n - 22) / 10;
        chk("edge_valid", 32'(e_valid), 32'd1);
        chk("edge_thru", 32'(e_thru), 32'(n - 22));
        chk("edge_flag", 32'(e_edge), 32'((r < 2) || (c < 2) || (c >= 8)));
        if (r == 2 && c == 2) chk("edge_center22", 32'(e_edge), 32'd0);
      end else begin
        chk("edge_fill", 32'(e_valid), 32'd0);
      end
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/line_window_center.md
Name: line_window_center

Overview:
- Parametrised successor to the fixed 11-row/640-column Gaussian pass-through aligner.
- Delays a raster pixel stream so that each output pixel is the centre of a KSIZE x KSIZE window ending at the newest input pixel.
- Downstream convolution stages (gauss, sobel, median) use it to align the unfiltered pixel and its coordinates with their filtered result.
- Adds a valid handshake, runtime line length, frame-start priming, and centre-coordinate output.

Parameters:
- PIX_W, 24, pixel width in bits (RGB888 default).
- LINE_MAX, 640, maximum line length; sets line-buffer depth.
- KSIZE, 11, window size; must be odd, 3..15; R = (KSIZE-1)/2.
- COORD_W, 13, width of column/row coordinates.

Ports:
- clk  in  1  single clock domain.
- rst_n  in  1  synchronous, active-low reset.
- pix_valid  in  1  input beat accepted on this cycle (replaces row_shift_en).
- sof  in  1  qualifies the current beat as the first pixel of a frame; ignored unless pix_valid.
- line_len  in  COORD_W  active pixels per line; sampled only on an accepted sof beat.
- pix_in  in  PIX_W  input pixel.
- pass_thru  out  PIX_W  delayed centre pixel.
- pass_valid  out  1  pass_thru/centre coordinates valid for one cycle.
- center_col  out  COORD_W  column of the emitted centre pixel.
- center_row  out  COORD_W  row of the emitted centre pixel.
- cfg_err  out  1  sticky; line_len out of range.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - All outputs go to 0 and the state goes to IDLE.
  - Line-buffer contents are don't-care.
  - A reset mid-frame discards the frame.
- States:
  - IDLE: waits for pix_valid & sof.
  - FILL: accepted-beat count n < R*line_len+R.
  - RUN: every accepted beat emits.
  - ERR: line_len invalid; held until the next valid sof or reset.
- Transitions:
  - IDLE -> FILL on pix_valid & sof with KSIZE <= line_len <= LINE_MAX.
  - If line_len is outside that range, go to ERR and set cfg_err=1; cfg_err stays set until reset.
  - FILL -> RUN on the beat where n reaches R*line_len+R. That beat emits.
  - Any state -> FILL (counters restarted) on pix_valid & sof with a valid line_len. The sof beat counts as n=0 of the new frame. No stale pixels from the previous frame are emitted afterwards.
- Counters:
  - Internal write column wraps line_len-1 -> 0 and increments the row.
  - The row counter saturates at 2^COORD_W-1.
  - External col/x_count inputs are no longer used.
- Storage:
  - R line buffers of LINE_MAX x PIX_W with a shared circular address.
  - Plus an R-stage pixel shift register.
  - Write, read and shift happen only on accepted beats. Gaps (pix_valid=0) freeze all state.
- Latency:
  - For an accepted beat k in RUN, on the next clk edge: pass_valid=1 and pass_thru = the pixel accepted at beat k-(R*line_len+R).
  - center_col and center_row give that pixel's coordinates, starting at 0,0.
  - pass_valid=0 on every other cycle; pass_thru holds its last value.
- Frame end: there is no eof. The last R rows are emitted only as the next frame's pixels push them out, and the sof restart discards them. This is the intended behaviour.
- Simultaneous sof and line wrap: sof wins.
- Width rule: pass_thru is bit-exact with pix_in; no arithmetic is applied to pixel data.

Optional Feature:
- Macro: LINE_WINDOW_EDGE_FLAG_EN.
- Defined:
  - Adds output pass_edge (1 bit), registered with pass_valid.
  - pass_edge=1 when center_row<R, center_col<R, or center_col>=line_len-R (the window overlaps the image border).
  - The bottom border is not flagged, because frame height is unknown.
  - Reset value is 0.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Shared package (video_pkg):
  - PIX_W default.
  - pixel_t typedef.
  - coord_t typedef (COORD_W).
  - LINE_MAX_DEFAULT.
  - State enum win_state_e {IDLE, FILL, RUN, ERR}.
- Sub-module line_buf_ram: single-port-write / single-read dual-port RAM, LINE_MAX x PIX_W, with 1-cycle registered read. Instantiate it R times in a generate loop.
- Shift register and counters stay in the top module.

Test Plan:
- Fill/align:
  - Stimulus: KSIZE=3, line_len=8; stream 0..63 continuously from sof.
  - Response: first pass_valid on the cycle after beat 9, with pass_thru=0 and center 0,0; then pixel n-9 each cycle; beat 17 gives pass_thru=8, center_row=1, center_col=0.
- Gaps:
  - Stimulus: same stream with pix_valid toggling 1,0,0,1.
  - Response: an identical output sequence, with pass_valid only after accepted beats.
- Restart:
  - Stimulus: sof reasserted at beat 30 with line_len=6.
  - Response: pass_valid low for the next 7 beats; then pass_thru equals the new frame's pixel 0.
- Config error:
  - Stimulus: sof with line_len=2 (KSIZE=3), then with line_len=700 (LINE_MAX=640).
  - Response: cfg_err=1, no pass_valid; a subsequent valid sof resumes normal output and cfg_err stays 1.
- Reset mid-frame:
  - Stimulus: rst_n=0 for 1 cycle at beat 20.
  - Response: outputs 0 on the next edge; no output until a new sof plus 9 beats.
- Edge flag (LINE_WINDOW_EDGE_FLAG_EN, KSIZE=5, line_len=10):
  - Response: pass_edge=1 for centre rows 0,1 and centre cols 0,1,8,9; pass_edge=0 at centre 2,2.
